icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Sequences instruction-cache refills for the fetch stage.
- On an icache miss it stalls fetch and issues a block-aligned AXI read.
- It then writes the returned block into the icache with a single one-cycle write enable.
- A branch redirect that arrives while fetch is stalled would otherwise be lost, so the block captures it and replays it once the refill completes.
- It sits between fetch_stage (i_icache_hit, PC, i_instr_we/i_instr_block, i_stall_fetch) and the AXI read master.

Parameters:
- ADDR_WIDTH, 64, address/PC width.
- BLOCK_WIDTH, 512, cache block width in bits. Offset bits OFS = log2(BLOCK_WIDTH/8) = 6.
- CNT_WIDTH, 32, width of the miss counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_arst  in  1  asynchronous active-low reset (asserted at 0).
- i_icache_hit  in  1  icache hit for the current PC (fetch_stage o_icache_hit).
- i_pc  in  ADDR_WIDTH  current fetch PC register value.
- i_stall_ext  in  1  backend stall request (hazard unit).
- i_branch_mispred  in  1  mispredict redirect from execute.
- i_pc_target_addr  in  ADDR_WIDTH  redirect target from execute.
- i_axi_done  in  1  read response valid, one-cycle pulse.
- i_axi_error  in  1  read response error, qualified by i_axi_done.
- i_axi_data  in  BLOCK_WIDTH  read response block.
- o_axi_read_start  out  1  one-cycle read request pulse.
- o_axi_read_addr  out  ADDR_WIDTH  block-aligned read address.
- o_instr_we  out  1  icache write enable.
- o_instr_block  out  BLOCK_WIDTH  block to write into the icache.
- o_stall_fetch  out  1  PC register hold.
- o_replay_valid  out  1  replay a captured redirect (ORed into fetch i_branch_mispred).
- o_replay_addr  out  ADDR_WIDTH  captured redirect target.
- o_busy  out  1  state != IDLE.
- o_axi_err  out  1  sticky error flag.
- o_miss_count  out  CNT_WIDTH  saturating miss counter.

Behaviour:
Reset (i_arst=0, asynchronous, may occur in any state):
- State goes to IDLE; all outputs, registers and counters go to 0. An in-flight AXI response is dropped.

FSM states: IDLE, ISSUE, WAIT, WRITE, REPLAY.
- IDLE:
  - Miss condition: miss = ~i_icache_hit & ~i_branch_mispred.
  - o_stall_fetch = i_stall_ext | miss.
  - On miss: latch addr_q = {i_pc[ADDR_WIDTH-1:OFS], OFS'b0}; o_miss_count += 1, saturating at all-ones; go to ISSUE.
  - A miss in the same cycle as i_branch_mispred is ignored (wrong-path PC).
- ISSUE: o_axi_read_start = 1 for exactly one cycle; go to WAIT.
- WAIT:
  - Hold until i_axi_done.
  - done & ~error: capture i_axi_data into blk_q; go to WRITE.
  - done & error: set o_axi_err (sticky until reset); no write; go to REPLAY if a redirect is pending, else IDLE. From IDLE the miss re-triggers a retry.
- WRITE: o_instr_we = 1 for exactly one cycle; o_instr_block = blk_q. Next state is REPLAY if a redirect is pending, else IDLE.
- REPLAY:
  - o_replay_valid = ~i_stall_ext; o_replay_addr = pend_addr_q.
  - o_stall_fetch = i_stall_ext.
  - Hold REPLAY while i_stall_ext = 1; otherwise clear pend and go to IDLE.
- Stall: o_stall_fetch = 1 in ISSUE, WAIT and WRITE. This keeps i_pc constant so the icache write indexes the missed block.
- o_axi_read_addr = addr_q; holds its value outside ISSUE.

Redirect capture:
- Applies in ISSUE, WAIT and WRITE.
- The first i_branch_mispred sets pend = 1 and pend_addr_q = i_pc_target_addr.
- Later redirects while pend = 1 are ignored (oldest wins).
- i_branch_mispred during REPLAY is ignored.
- i_branch_mispred in IDLE passes straight to fetch; not captured.

Latency:
- Miss detected at cycle 0; read_start at cycle 1.
- done at cycle N gives instr_we at N+1.
- Stall drops in the cycle after WRITE, or after the replay is accepted.

Test Plan:
- Reset, then i_icache_hit=1 for 10 cycles -> o_busy=0, o_stall_fetch=0, o_miss_count=0, no read_start.
- i_pc=0x80000044, hit=0; i_axi_done at cycle 5 with data D -> read_start only at cycle 1 with addr 0x80000040; stall in cycles 0..6; instr_we=1 only at cycle 6 with block D; miss_count=1.
- During WAIT, mispredict to 0x80000100, then to 0x80000200 -> after WRITE, REPLAY with o_replay_valid=1, o_replay_addr=0x80000100; second redirect ignored.
- Same flow with i_stall_ext=1 for 3 cycles on entering REPLAY -> replay_valid=0 for 3 cycles, then 1 for one cycle, then IDLE.
- i_axi_done with i_axi_error=1 -> no instr_we, o_axi_err=1; hit still 0 -> new read_start, miss_count=2.
- Drop i_arst mid-WAIT, then done arrives after release -> all outputs 0, state IDLE, no instr_we.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill sequencer: stalls fetch on a miss, reads the block over AXI,
// writes it into the icache and replays any branch redirect that arrived meanwhile.
module icache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned BLOCK_WIDTH = 512,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_icache_hit,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic                   i_stall_ext,
  input  logic                   i_branch_mispred,
  input  logic [ADDR_WIDTH-1:0]  i_pc_target_addr,
  input  logic                   i_axi_done,
  input  logic                   i_axi_error,
  input  logic [BLOCK_WIDTH-1:0] i_axi_data,
  output logic                   o_axi_read_start,
  output logic [ADDR_WIDTH-1:0]  o_axi_read_addr,
  output logic                   o_instr_we,
  output logic [BLOCK_WIDTH-1:0] o_instr_block,
  output logic                   o_stall_fetch,
  output logic                   o_replay_valid,
  output logic [ADDR_WIDTH-1:0]  o_replay_addr,
  output logic                   o_busy,
  output logic                   o_axi_err,
  output logic [CNT_WIDTH-1:0]   o_miss_count
);

  localparam int unsigned OFS = $clog2(BLOCK_WIDTH / 8);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_REPLAY = 3'd4
  } state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BLOCK_WIDTH-1:0] blk_q;
  logic                   pend_q;
  logic [ADDR_WIDTH-1:0]  pend_addr_q;
  logic                   err_q;
  logic [CNT_WIDTH-1:0]   cnt_q;

  logic miss;
  logic in_refill;
  logic capture;
  logic pend_now;
  logic unused_pc_ofs;

  assign miss      = ~i_icache_hit & ~i_branch_mispred;
  assign in_refill = (state_q == S_ISSUE) | (state_q == S_WAIT) | (state_q == S_WRITE);
  assign capture   = in_refill & i_branch_mispred & ~pend_q;
  // A redirect arriving in the exit cycle itself must still steer the exit to REPLAY.
  assign pend_now  = pend_q | capture;
  assign unused_pc_ofs = ^i_pc[OFS-1:0];

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      blk_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (capture) begin
        pend_q      <= 1'b1;
        pend_addr_q <= i_pc_target_addr;
      end
      case (state_q)
        S_IDLE: begin
          if (miss) begin
            addr_q <= {i_pc[ADDR_WIDTH-1:OFS], OFS'(0)};
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (i_axi_done) begin
            if (i_axi_error) begin
              err_q   <= 1'b1;
              state_q <= pend_now ? S_REPLAY : S_IDLE;
            end else begin
              blk_q   <= i_axi_data;
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: state_q <= pend_now ? S_REPLAY : S_IDLE;
        S_REPLAY: begin
          if (!i_stall_ext) begin
            pend_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Fetch hold: combinational in IDLE/REPLAY so fetch reacts in the same cycle.
  always_comb begin
    o_stall_fetch = 1'b1;
    case (state_q)
      S_IDLE:   o_stall_fetch = i_stall_ext | miss;
      S_REPLAY: o_stall_fetch = i_stall_ext;
      default:  o_stall_fetch = 1'b1;
    endcase
  end

  assign o_axi_read_start = (state_q == S_ISSUE);
  assign o_axi_read_addr  = addr_q;
  assign o_instr_we       = (state_q == S_WRITE);
  assign o_instr_block    = blk_q;
  assign o_replay_valid   = (state_q == S_REPLAY) & ~i_stall_ext;
  assign o_replay_addr    = pend_addr_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_axi_err        = err_q;
  assign o_miss_count     = cnt_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: directed scenarios plus randomized refills
// checked against a transaction-level timing model of the refill sequence.
module tb_icache_refill_ctrl;

  localparam int unsigned AW    = 64;
  localparam int unsigned BW    = 512;
  localparam int unsigned CW    = 3;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          i_arst;
  logic          i_icache_hit;
  logic [AW-1:0] i_pc;
  logic          i_stall_ext;
  logic          i_branch_mispred;
  logic [AW-1:0] i_pc_target_addr;
  logic          i_axi_done;
  logic          i_axi_error;
  logic [BW-1:0] i_axi_data;
  logic          o_axi_read_start;
  logic [AW-1:0] o_axi_read_addr;
  logic          o_instr_we;
  logic [BW-1:0] o_instr_block;
  logic          o_stall_fetch;
  logic          o_replay_valid;
  logic [AW-1:0] o_replay_addr;
  logic          o_busy;
  logic          o_axi_err;
  logic [CW-1:0] o_miss_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;
  bit exp_err  = 1'b0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_arst(i_arst), .i_icache_hit(i_icache_hit), .i_pc(i_pc),
    .i_stall_ext(i_stall_ext), .i_branch_mispred(i_branch_mispred),
    .i_pc_target_addr(i_pc_target_addr), .i_axi_done(i_axi_done),
    .i_axi_error(i_axi_error), .i_axi_data(i_axi_data),
    .o_axi_read_start(o_axi_read_start), .o_axi_read_addr(o_axi_read_addr),
    .o_instr_we(o_instr_we), .o_instr_block(o_instr_block),
    .o_stall_fetch(o_stall_fetch), .o_replay_valid(o_replay_valid),
    .o_replay_addr(o_replay_addr), .o_busy(o_busy), .o_axi_err(o_axi_err),
    .o_miss_count(o_miss_count)
  );

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_icache_hit = 1'b1; i_stall_ext = 1'b0; i_branch_mispred = 1'b0;
    i_axi_done = 1'b0; i_axi_error = 1'b0;
  endtask

  task automatic test_reset();
    i_arst = 1'b0; i_pc = '0; i_pc_target_addr = '0; i_axi_data = '0;
    idle_inputs();
    tick(); tick();
    #1;
    n_checks++;
    if ({o_busy, o_stall_fetch, o_axi_read_start, o_instr_we, o_replay_valid, o_axi_err} !== 6'b0 ||
        o_miss_count !== '0 || o_axi_read_addr !== '0 || o_replay_addr !== '0 || o_instr_block !== '0) begin
      $display("FAIL reset_outputs: busy=%b stall=%b cnt=%0d err=%b expected all zero",
               o_busy, o_stall_fetch, o_miss_count, o_axi_err);
      n_errors++;
    end
    tick();
    i_arst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      i_pc = {$urandom, $urandom};
      #1;
      n_checks++;
      if (o_busy !== 1'b0 || o_stall_fetch !== 1'b0 || o_axi_read_start !== 1'b0 || o_miss_count !== '0) begin
        $display("FAIL hit_idle c=%0d: busy=%b stall=%b rs=%b cnt=%0d expected 0 0 0 0",
                 c, o_busy, o_stall_fetch, o_axi_read_start, o_miss_count);
        n_errors++;
      end
      tick();
    end
  endtask

  // Drives one refill starting in an IDLE cycle with a miss; predicts every cycle from the
  // latency rules: issue at 1, done at done_c, write at done_c+1, optional replay after.
  task automatic run_refill(input logic [AW-1:0] pc, input int done_c, input logic [BW-1:0] data,
                            input bit err, input int r1_c, input logic [AW-1:0] r1_a,
                            input int r2_c, input logic [AW-1:0] r2_a, input int ext_n);
    int end_c, rep_c, last_c;
    bit pend, e_rs, e_we, e_busy, e_rv, e_stall;
    end_c  = err ? done_c : done_c + 1;
    pend   = (r1_c >= 1) && (r1_c <= end_c);
    rep_c  = end_c + 1;
    last_c = pend ? rep_c + ext_n : end_c;
    for (int c = 0; c <= last_c; c++) begin
      i_icache_hit     = 1'b0;
      i_pc             = pc;
      i_branch_mispred = (c == r1_c) || (c == r2_c);
      i_pc_target_addr = (c == r1_c) ? r1_a : r2_a;
      i_axi_done       = (c == done_c);
      i_axi_error      = err && (c == done_c);
      i_axi_data       = (c == done_c) ? data : rand_blk();
      if (c == 0) i_stall_ext = 1'b0;
      else if (pend && c >= rep_c) i_stall_ext = (c < rep_c + ext_n);
      else i_stall_ext = 1'($urandom_range(0, 1));
      #1;
      e_rs    = (c == 1);
      e_we    = !err && (c == done_c + 1);
      e_busy  = (c != 0);
      e_rv    = pend && (c == last_c);
      e_stall = !(pend && c == last_c);
      n_checks++;
      if (o_axi_read_start !== e_rs || o_instr_we !== e_we || o_busy !== e_busy ||
          o_replay_valid !== e_rv || o_stall_fetch !== e_stall) begin
        $display("FAIL refill_ctl c=%0d: rs/we/busy/rv/stall=%b%b%b%b%b expected %b%b%b%b%b",
                 c, o_axi_read_start, o_instr_we, o_busy, o_replay_valid, o_stall_fetch,
                 e_rs, e_we, e_busy, e_rv, e_stall);
        n_errors++;
      end
      if (e_rs) begin
        n_checks++;
        if (o_axi_read_addr !== {pc[AW-1:6], 6'b0}) begin
          $display("FAIL read_addr: got %h expected %h", o_axi_read_addr, {pc[AW-1:6], 6'b0});
          n_errors++;
        end
      end
      if (e_we) begin
        n_checks++;
        if (o_instr_block !== data) begin
          $display("FAIL instr_block: got %h expected %h", o_instr_block[63:0], data[63:0]);
          n_errors++;
        end
      end
      if (e_rv) begin
        n_checks++;
        if (o_replay_addr !== r1_a) begin
          $display("FAIL replay_addr: got %h expected %h", o_replay_addr, r1_a);
          n_errors++;
        end
      end
      if (c == 0 && exp_cnt != CMAX) exp_cnt++;
      if (err && c == done_c) exp_err = 1'b1;
      tick();
    end
    idle_inputs();
    i_icache_hit = !err;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_stall_fetch !== err || o_instr_we !== 1'b0 ||
        o_miss_count !== CW'(exp_cnt) || o_axi_err !== exp_err) begin
      $display("FAIL refill_end: busy=%b stall=%b we=%b cnt=%0d err=%b expected 0 %b 0 %0d %b",
               o_busy, o_stall_fetch, o_instr_we, o_miss_count, o_axi_err, err, exp_cnt, exp_err);
      n_errors++;
    end
  endtask

  task automatic test_refill();
    run_refill(64'h8000_0044, 5, rand_blk(), 1'b0, -1, '0, -1, '0, 0);
    tick();
  endtask

  task automatic test_redirect();
    run_refill(64'h8000_0044, 5, rand_blk(), 1'b0, 3, 64'h8000_0100, 4, 64'h8000_0200, 0);
    tick();
  endtask

  task automatic test_replay_stall();
    run_refill(64'h8000_1088, 4, rand_blk(), 1'b0, 2, 64'h8000_0100, 5, 64'h8000_0200, 3);
    tick();
  endtask

  task automatic test_error();
    run_refill(64'h8000_2010, 3, rand_blk(), 1'b1, -1, '0, -1, '0, 0);
    run_refill(64'h8000_2010, 4, rand_blk(), 1'b0, -1, '0, -1, '0, 0);
    tick();
  endtask

  task automatic test_idle_redirect();
    i_icache_hit = 1'b0; i_branch_mispred = 1'b1; i_pc_target_addr = 64'h1234_0000;
    #1;
    n_checks++;
    if (o_stall_fetch !== 1'b0 || o_busy !== 1'b0) begin
      $display("FAIL idle_mispred: stall=%b busy=%b expected 0 0", o_stall_fetch, o_busy);
      n_errors++;
    end
    tick();
    idle_inputs();
    i_stall_ext = 1'b1;
    #1;
    n_checks++;
    if (o_stall_fetch !== 1'b1 || o_busy !== 1'b0 || o_miss_count !== CW'(exp_cnt)) begin
      $display("FAIL idle_ext_stall: stall=%b busy=%b cnt=%0d expected 1 0 %0d",
               o_stall_fetch, o_busy, o_miss_count, exp_cnt);
      n_errors++;
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_midwait();
    i_icache_hit = 1'b0; i_pc = 64'h8000_3000;
    tick(); tick(); tick();
    #2;
    i_arst = 1'b0;
    i_icache_hit = 1'b1;
    #1;
    exp_cnt = 0; exp_err = 1'b0;
    n_checks++;
    if ({o_busy, o_stall_fetch, o_axi_read_start, o_instr_we, o_replay_valid, o_axi_err} !== 6'b0 ||
        o_miss_count !== '0 || o_axi_read_addr !== '0 || o_replay_addr !== '0 || o_instr_block !== '0) begin
      $display("FAIL reset_midwait: busy=%b stall=%b cnt=%0d err=%b addr=%h expected all zero",
               o_busy, o_stall_fetch, o_miss_count, o_axi_err, o_axi_read_addr);
      n_errors++;
    end
    tick();
    i_arst = 1'b1;
    i_axi_done = 1'b1; i_axi_data = rand_blk();
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (o_instr_we !== 1'b0 || o_busy !== 1'b0 || o_instr_block !== '0) begin
        $display("FAIL post_reset_done c=%0d: we=%b busy=%b expected 0 0", c, o_instr_we, o_busy);
        n_errors++;
      end
      tick();
      i_axi_done = 1'b0;
    end
  endtask

  task automatic test_random();
    int done_c, r1, r2, ext, end_c;
    bit err;
    for (int it = 0; it < 24; it++) begin
      done_c = 2 + $urandom_range(0, 6);
      err    = (it != 23) && ($urandom_range(0, 3) == 0);
      end_c  = err ? done_c : done_c + 1;
      r1     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, end_c) : -1;
      r2     = (r1 < 0) ? -1 : r1 + $urandom_range(1, 4);
      ext    = $urandom_range(0, 3);
      run_refill({$urandom, $urandom}, done_c, rand_blk(), err, r1, {$urandom, $urandom},
                 r2, {$urandom, $urandom}, ext);
      if (!err) repeat ($urandom_range(0, 2)) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_refill();
    test_redirect();
    test_replay_stall();
    test_error();
    test_idle_redirect();
    test_reset_midwait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
